// File: rtl/uart_mode_ctrl.sv
// uart_mode_ctrl
//   Selects one of NUM_MODES display/function modes and keeps one sub-mode bit
//   per mode. Commands come in as ASCII bytes from the UART RX path (qualified
//   by pc_valid_i) or as a debounced "next" button pulse. A lock key freezes
//   every command except the lock key itself.
//
// Ports
//   clk_i           system clock
//   rst_i           synchronous reset, active low
//   pc_data_i       ASCII byte from UART RX
//   pc_valid_i      one-cycle strobe qualifying pc_data_i
//   btn_next_i      one-cycle debounced button pulse, acts as NEXT
//   m_sel_o         current mode index (registered)
//   m_sub_o         sub-mode bit of the current mode
//   m_sub_vec_o     sub-mode bit of every mode (registered)
//   locked_o        lock state (registered)
//   mode_changed_o  one-cycle pulse when m_sel_o changes value
//
// Lock FSM
//   state    | meaning
//   UNLOCKED | every command executes
//   LOCKED   | only the lock key is honoured

module uart_mode_ctrl #(
  parameter int unsigned NUM_MODES  = 4,
  parameter int unsigned MODE_W     = 2,
  parameter int unsigned RESET_MODE = 0,
  parameter logic [7:0]  KEY_NEXT   = 8'h4D,
  parameter logic [7:0]  KEY_PREV   = 8'h4E,
  parameter logic [7:0]  KEY_SUB    = 8'h48,
  parameter logic [7:0]  KEY_LOCK   = 8'h4C,
  parameter logic [7:0]  DIGIT_BASE = 8'h30
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           pc_data_i,
  input  logic                 pc_valid_i,
  input  logic                 btn_next_i,
  output logic [MODE_W-1:0]    m_sel_o,
  output logic                 m_sub_o,
  output logic [NUM_MODES-1:0] m_sub_vec_o,
  output logic                 locked_o,
  output logic                 mode_changed_o
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0] RESET_SEL = MODE_W'(RESET_MODE);

  lock_state_e            state_q, state_d;
  logic [MODE_W-1:0]      m_sel_q, m_sel_d;
  logic [NUM_MODES-1:0]   m_sub_vec_q, m_sub_vec_d;
  logic                   mode_changed_q, mode_changed_d;

  // Letter keys also accept their lowercase form (bit 5 set).
  function automatic logic key_hit(input logic [7:0] b, input logic [7:0] k);
    return (b == k) || (b == (k | 8'h20));
  endfunction

  logic       hit_next, hit_prev, hit_sub, hit_lock, hit_digit, digit_ok;
  logic       cmd_known;
  logic [7:0] digit_off;
  logic       sel_bad;
  logic [MODE_W-1:0] sel_inc, sel_dec;

  // Command decode
  always_comb begin
    hit_next  = key_hit(pc_data_i, KEY_NEXT);
    hit_prev  = key_hit(pc_data_i, KEY_PREV);
    hit_sub   = key_hit(pc_data_i, KEY_SUB);
    hit_lock  = key_hit(pc_data_i, KEY_LOCK);
    digit_off = pc_data_i - DIGIT_BASE;
    hit_digit = (pc_data_i >= DIGIT_BASE) && (digit_off <= 8'd9);
    // A digit beyond the mode count is still a recognised key (it claims the
    // cycle over btn_next) but selects nothing.
    digit_ok  = hit_digit && (32'(digit_off) < NUM_MODES);
    cmd_known = pc_valid_i && (hit_next || hit_prev || hit_sub || hit_lock || hit_digit);
  end

  // Wrap by explicit compare so non-power-of-2 mode counts work.
  always_comb begin
    sel_bad = 32'(m_sel_q) >= NUM_MODES;
    sel_inc = (m_sel_q == LAST_MODE) ? '0 : m_sel_q + MODE_W'(1);
    sel_dec = (m_sel_q == '0) ? LAST_MODE : m_sel_q - MODE_W'(1);
  end

  // Next-state logic
  always_comb begin
    state_d        = state_q;
    m_sel_d        = m_sel_q;
    m_sub_vec_d    = m_sub_vec_q;
    mode_changed_d = 1'b0;

    unique case (state_q)
      UNLOCKED: begin
        if (pc_valid_i && hit_lock) begin
          state_d = LOCKED;
        end else if (cmd_known) begin
          if (hit_next) begin
            m_sel_d = sel_inc;
          end else if (hit_prev) begin
            m_sel_d = sel_dec;
          end else if (hit_sub) begin
            for (int unsigned i = 0; i < NUM_MODES; i++) begin
              if (32'(m_sel_q) == i) begin
                m_sub_vec_d[i] = ~m_sub_vec_q[i];
              end
            end
          end else if (digit_ok) begin
            m_sel_d = MODE_W'(digit_off);
          end
        end else if (btn_next_i) begin
          m_sel_d = sel_inc;
        end
      end
      LOCKED: begin
        if (pc_valid_i && hit_lock) begin
          state_d = UNLOCKED;
        end
      end
      default: state_d = UNLOCKED;
    endcase

    // An out-of-range index (e.g. upset flop) is recovered on the next edge.
    if (sel_bad) begin
      m_sel_d = RESET_SEL;
    end

    mode_changed_d = (m_sel_d != m_sel_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q        <= UNLOCKED;
      m_sel_q        <= RESET_SEL;
      m_sub_vec_q    <= '0;
      mode_changed_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      m_sel_q        <= m_sel_d;
      m_sub_vec_q    <= m_sub_vec_d;
      mode_changed_q <= mode_changed_d;
    end
  end

  // Loop select avoids an index wider than the vector when NUM_MODES < 2**MODE_W.
  always_comb begin
    m_sub_o = 1'b0;
    for (int unsigned i = 0; i < NUM_MODES; i++) begin
      if (32'(m_sel_q) == i) begin
        m_sub_o = m_sub_vec_q[i];
      end
    end
  end

  assign m_sel_o        = m_sel_q;
  assign m_sub_vec_o    = m_sub_vec_q;
  assign locked_o       = (state_q == LOCKED);
  assign mode_changed_o = mode_changed_q;

endmodule

// File: tb/tb_uart_mode_ctrl.sv
// Testbench for uart_mode_ctrl: two instances (4 modes and 3 modes) share the
// same stimulus and are compared every cycle against a behavioural model.

module tb_uart_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pc_data;
  logic       pc_valid;
  logic       btn_next;

  logic [1:0] sel4, sel3;
  logic       sub4, sub3;
  logic [3:0] vec4;
  logic [2:0] vec3;
  logic       lk4, lk3, chg4, chg3;

  always #5 clk = ~clk;

  uart_mode_ctrl #(.NUM_MODES(4), .MODE_W(2)) dut4 (
    .clk_i(clk), .rst_i(rst_n), .pc_data_i(pc_data), .pc_valid_i(pc_valid),
    .btn_next_i(btn_next), .m_sel_o(sel4), .m_sub_o(sub4), .m_sub_vec_o(vec4),
    .locked_o(lk4), .mode_changed_o(chg4)
  );

  uart_mode_ctrl #(.NUM_MODES(3), .MODE_W(2)) dut3 (
    .clk_i(clk), .rst_i(rst_n), .pc_data_i(pc_data), .pc_valid_i(pc_valid),
    .btn_next_i(btn_next), .m_sel_o(sel3), .m_sub_o(sub3), .m_sub_vec_o(vec3),
    .locked_o(lk3), .mode_changed_o(chg3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: index 0 = 4-mode instance, index 1 = 3-mode instance.
  int unsigned md_n   [2] = '{4, 3};
  int unsigned md_sel [2];
  int unsigned md_vec [2];
  bit          md_lock[2];
  bit          md_chg [2];

  function automatic logic [7:0] fold_case(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    return b;
  endfunction

  task automatic model_step(input int i, input logic [7:0] d, input bit v, input bit b, input bit r);
    int unsigned old = md_sel[i];
    int unsigned n   = md_n[i];
    logic [7:0]  c   = fold_case(d);
    bit          dig = (d >= 8'h30) && (d <= 8'h39);
    int unsigned k   = 32'(d) - 32'h30;
    if (r) begin
      md_sel[i] = 0; md_vec[i] = 0; md_lock[i] = 0; md_chg[i] = 0;
      return;
    end
    if (md_lock[i]) begin
      if (v && c == 8'h4C) md_lock[i] = 0;
    end else if (v && c == 8'h4C) md_lock[i] = 1;
    else if (v && c == 8'h4D) md_sel[i] = (md_sel[i] + 1) % n;
    else if (v && c == 8'h4E) md_sel[i] = (md_sel[i] + n - 1) % n;
    else if (v && c == 8'h48) md_vec[i] = md_vec[i] ^ (32'd1 << md_sel[i]);
    else if (v && dig) begin
      if (k < n) md_sel[i] = k;
    end else if (b) md_sel[i] = (md_sel[i] + 1) % n;
    md_chg[i] = (md_sel[i] != old);
  endtask

  task automatic compare_all();
    check_val("d4.sel",  32'(sel4), md_sel[0]);
    check_val("d4.vec",  32'(vec4), md_vec[0]);
    check_val("d4.sub",  32'(sub4), (md_vec[0] >> md_sel[0]) & 1);
    check_val("d4.lock", 32'(lk4),  32'(md_lock[0]));
    check_val("d4.chg",  32'(chg4), 32'(md_chg[0]));
    check_val("d3.sel",  32'(sel3), md_sel[1]);
    check_val("d3.vec",  32'(vec3), md_vec[1]);
    check_val("d3.sub",  32'(sub3), (md_vec[1] >> md_sel[1]) & 1);
    check_val("d3.lock", 32'(lk3),  32'(md_lock[1]));
    check_val("d3.chg",  32'(chg3), 32'(md_chg[1]));
  endtask

  // Drive one cycle of inputs, let the DUT sample, then compare 2 ns later.
  task automatic step(input logic [7:0] d, input bit v, input bit b, input bit r);
    pc_data  = d;
    pc_valid = v;
    btn_next = b;
    rst_n    = ~r;
    @(posedge clk);
    model_step(0, d, v, b, r);
    model_step(1, d, v, b, r);
    #2;
    compare_all();
  endtask

  task automatic cmd(input logic [7:0] d);
    step(d, 1'b1, 1'b0, 1'b0);
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] keys [4] = '{8'h4D, 8'h4E, 8'h48, 8'h4C};
    case ($urandom_range(0, 9))
      0, 1, 2: return keys[$urandom_range(0, 3)];
      3:       return keys[$urandom_range(0, 3)] | 8'h20;
      4, 5:    return 8'(8'h30 + $urandom_range(0, 9));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    int pulses;
    logic [7:0] d;
    bit v, b, r;

    pc_data = 8'h00; pc_valid = 1'b0; btn_next = 1'b0; rst_n = 1'b0;

    // Reset and basic step
    step(8'h00, 0, 0, 1);
    step(8'h00, 0, 0, 1);
    check_val("rst.sel4", 32'(sel4), 0);
    check_val("rst.lock4", 32'(lk4), 0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cmd("M");
      pulses += int'(chg4);
      step(8'h00, 0, 0, 0);
      pulses += int'(chg4);
    end
    check_val("step.pulses", 32'(pulses), 4);
    check_val("step.sel4", 32'(sel4), 0);
    check_val("step.vec4", 32'(vec4), 0);

    // Prev, digits, lowercase on the 3-mode instance
    step(8'h00, 0, 0, 1);
    cmd("N");
    check_val("prev.wrap3", 32'(sel3), 2);
    check_val("prev.chg3", 32'(chg3), 1);
    cmd("1");
    cmd("1");
    check_val("digit.same.chg3", 32'(chg3), 0);
    cmd("7");
    check_val("digit.oor.sel3", 32'(sel3), 1);
    cmd("m");
    check_val("lower.sel3", 32'(sel3), 2);

    // Sub bits
    cmd("1");
    cmd("H");
    check_val("sub.vec4", 32'(vec4), 32'b0010);
    check_val("sub.sub4", 32'(sub4), 1);
    cmd("M");
    check_val("sub.after_m", 32'(sub4), 0);
    cmd("1");
    check_val("sub.retain", 32'(sub4), 1);
    cmd("h");
    cmd("h");
    check_val("sub.twice", 32'(sub4), 1);

    // Lock
    cmd("L");
    check_val("lock.on", 32'(lk4), 1);
    cmd("M");
    cmd("3");
    cmd("H");
    step(8'h00, 0, 1, 0);
    check_val("lock.sel4", 32'(sel4), 1);
    check_val("lock.vec4", 32'(vec4), 32'b0010);
    cmd("L");
    cmd("M");
    check_val("unlock.sel4", 32'(sel4), 2);

    // Held data without strobe, then simultaneous strobe and button
    for (int i = 0; i < 10; i++) step("M", 0, 0, 0);
    check_val("nostrobe.sel4", 32'(sel4), 2);
    step("N", 1, 1, 0);
    check_val("prio.key.sel4", 32'(sel4), 1);
    cmd("2");
    step(8'h41, 1, 1, 0);
    check_val("prio.btn.sel4", 32'(sel4), 3);
    cmd("2");
    step("L", 1, 1, 0);
    check_val("prio.lock.sel4", 32'(sel4), 2);
    cmd("L");

    // Reset mid-operation
    step(8'h00, 0, 0, 1);
    cmd("1"); cmd("H"); cmd("3"); cmd("H"); cmd("L");
    check_val("pre.vec4", 32'(vec4), 32'b1010);
    step("L", 1, 0, 1);
    check_val("midrst.sel4", 32'(sel4), 0);
    check_val("midrst.vec4", 32'(vec4), 0);
    check_val("midrst.lock4", 32'(lk4), 0);
    check_val("midrst.chg4", 32'(chg4), 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      d = rand_byte();
      v = ($urandom_range(0, 2) != 0);
      b = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 150) == 0);
      // An out-of-range digit together with the button is left unexercised.
      if (v && d >= 8'h33 && d <= 8'h39) b = 0;
      step(d, v, b, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
